mem_responder: RTL
==================

Name: mem_responder

Overview:
- Word-organised data-memory responder for the multicycle MIPS core; it is the far end of the core's load/store memory access.
- Accepts one request at a time from the core over a req/ack handshake, inserts a programmable number of wait states, then commits the write or returns read data with a one-cycle ack.
- Flags misaligned and out-of-range accesses so the controller can stall or trap.

Parameters:
- DEPTH, 1024, number of 32-bit words; valid word index 0..DEPTH-1.
- AW, 10, word-index width, equal to clog2(DEPTH).
- WAIT_CYCLES, 2, wait states between request accept and ack; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request valid; held high by the initiator until ack.
- we  input  1  1 = store, 0 = load; sampled at accept.
- addr  input  32  byte address; sampled at accept.
- wdata  input  32  store data; sampled at accept.
- be  input  4  byte enables, be[i] selects wdata[8i+7:8i]; sampled at accept.
- ack  output  1  one-cycle completion pulse, registered.
- rdata  output  32  load data, valid while ack=1; registered.
- err  output  1  error for the completing access, valid while ack=1.
- busy  output  1  high from the accept edge until the edge that clears ack.

Behaviour:
- Reset is asynchronous, takes effect immediately and dominates everything:
  - state=IDLE, ack=0, rdata=0, err=0, busy=0, wait counter=0.
  - Memory array is not cleared.
  - Reset mid-transaction abandons the transaction; a pending write is never committed.
- States:
  - IDLE: if req=1 at an edge, latch we/addr/wdata/be; go to WAIT with counter=WAIT_CYCLES-1, or go directly to RESP if WAIT_CYCLES=0.
  - WAIT: decrement the counter each edge; when counter=0, go to RESP.
  - RESP: at this edge set ack=1, drive rdata/err, commit any write, go to DONE.
  - DONE: ack=1 for this cycle only; next edge clears ack/err and returns to IDLE; rdata holds its last value.
- Latency: ack is high exactly WAIT_CYCLES+1 cycles after the accept edge.
- Minimum spacing between accepts is WAIT_CYCLES+3 edges. A req held high through DONE is treated as a new request at the first IDLE edge, so the initiator must drop req in the ack cycle.
- req falling after accept does not cancel the transaction. req changes during WAIT/RESP/DONE are ignored.
- Word index is addr[AW+1:2].
- Error conditions:
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr[31:2] >= DEPTH.
  - On error: err=1 with ack, rdata=0, no memory write.
- Store: for each i with be[i]=1, mem[idx][8i+7:8i] <= wdata[8i+7:8i]; other bytes unchanged. be=0000 completes normally with err=0 and writes nothing.
- Load: rdata = mem[idx], the full word regardless of be; byte selection is done by the core.
- Read-after-write to the same word in the next transaction returns the new data.
- busy=1 from the accept edge until the edge that clears ack.

Test Plan:
- WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, be=1111, then load 0x10 → ack 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
- Word 0x20 preloaded with 0x11223344; store be=0101, wdata=0xAABBCCDD; load 0x20 → rdata=0x11BB33DD.
- Load addr=0x1002 (misaligned) and addr=DEPTH*4 (out of range) → ack with err=1, rdata=0. A store to DEPTH*4 leaves word 0 and word DEPTH-1 unchanged.
- WAIT_CYCLES=0: back-to-back loads with req dropped on ack → ack 1 cycle after each accept, accepts 3 edges apart, busy low for one cycle between transactions.
- Assert reset during WAIT of a store to 0x40 whose old value is 0x0 → ack/err/busy go to 0 immediately. A later load of 0x40 returns 0x00000000.
- Drop req one cycle after accept with WAIT_CYCLES=2 → transaction still completes: ack pulses once and the write is committed.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-organised data memory responder with req/ack handshake and wait states
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Counter preload; the WAIT state is skipped entirely when no wait states are configured.
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic [AW-1:0] idx;
  logic          acc_err;
  logic          do_write;

  // Decode the latched request: word index, error classification, write commit strobe.
  always_comb begin
    idx      = addr_q[AW+1:2];
    acc_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
    do_write = (state_q == S_RESP) && we_q && !acc_err;
  end

  // Next-state logic for the handshake FSM and the registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          busy_d  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        ack_d   = 1'b1;
        err_d   = acc_err;
        rdata_d = acc_err ? 32'h0 : mem[idx];
        state_d = S_DONE;
      end
      default: begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Byte-masked store into the array; contents survive reset and reset forces the FSM out of RESP.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
